// File: rtl/contador_binario_behav_pkg.sv
// Shared constants for the free-running binary counter.
// Width default and all-ones mask helper.
package contador_binario_behav_pkg;

  localparam int CNT_W_DEFAULT = 4;

  // All-ones value for a w-bit count (1..32), LSB-aligned.
  function automatic logic [31:0] cnt_max(
    input int unsigned w
  );
    logic [32:0] m;
    m = (33'd1 << w) - 33'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/contador_binario_behav_if.sv
// Output bundle of the binary counter.
// The counter drives it; consumers only read it.
interface contador_binario_behav_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output q,
    output tc,
    output wrap
  );

  modport slave (
    input q,
    input tc,
    input wrap
  );

endinterface

// File: rtl/contador_binario_tc.sv
// Terminal-count decode and registered wrap pulse.
// Kept apart from the count register itself.
module contador_binario_tc
  import contador_binario_behav_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [31:0] MAX32 = cnt_max(WIDTH);
  localparam logic [WIDTH-1:0] CNT_MAX =
    MAX32[WIDTH-1:0];

  assign tc = (q == CNT_MAX);

  // A reset edge at all-ones must not flag a wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule

// File: rtl/contador_binario_behav.sv
// Free-running modulo-2^WIDTH up-counter.
// Synchronous active-low reset; counts every edge.
module contador_binario_behav
  import contador_binario_behav_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  contador_binario_behav_if.master bus
);

  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q + WIDTH'(1);
    end
  end

  contador_binario_tc #(
    .WIDTH (WIDTH)
  ) u_tc (
    .clk  (clk),
    .rst  (rst),
    .q    (q),
    .tc   (tc),
    .wrap (wrap)
  );

  assign bus.q    = q;
  assign bus.tc   = tc;
  assign bus.wrap = wrap;

endmodule

// File: tb/tb_contador_binario_behav.sv
// Directed bench for the binary counter.
// Covers WIDTH=4 and WIDTH=3 instances.
module tb_contador_binario_behav;
  import contador_binario_behav_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst3 = 1'b0;

  always #5 clk = ~clk;

  contador_binario_behav_if #(.WIDTH(4)) bus4 ();
  contador_binario_behav_if #(.WIDTH(3)) bus3 ();

  contador_binario_behav #(
    .WIDTH (4)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.master)
  );

  contador_binario_behav #(
    .WIDTH (3)
  ) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3.master)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic       r,
    input logic [3:0] q,
    input logic       t,
    input logic       w
  );
    vec_t v;
    v.rst  = r;
    v.q    = q;
    v.tc   = t;
    v.wrap = w;
    vecs.push_back(v);
  endfunction

  task automatic chk(
    input string       nm,
    input int          idx,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h exp %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held two edges
    add(1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 1'b0, 1'b0);
    // 20 counts: 1..15,0,1..4
    for (int k = 1; k <= 20; k++) begin
      add(1'b1, 4'(k % 16),
          (k % 16) == 15, k == 16);
    end
    // up to 7, reset two edges, resume
    add(1'b1, 4'd5, 1'b0, 1'b0);
    add(1'b1, 4'd6, 1'b0, 1'b0);
    add(1'b1, 4'd7, 1'b0, 1'b0);
    add(1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 4'd1, 1'b0, 1'b0);
    add(1'b1, 4'd2, 1'b0, 1'b0);
    add(1'b1, 4'd3, 1'b0, 1'b0);
    for (int v = 4; v <= 15; v++) begin
      add(1'b1, 4'(v), v == 15, 1'b0);
    end
    // reset on the edge where q==15
    add(1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b1, 4'd1, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      step();
      chk("q4", i, 32'(bus4.q), 32'(vecs[i].q));
      chk("tc4", i, 32'(bus4.tc), 32'(vecs[i].tc));
      chk("wrap4", i, 32'(bus4.wrap),
          32'(vecs[i].wrap));
    end

    // WIDTH=3: 1..7,0,1,2
    chk("q3_rst", 0, 32'(bus3.q), 32'd0);
    chk("wrap3_rst", 0, 32'(bus3.wrap), 32'd0);
    rst3 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("q3", i, 32'(bus3.q), 32'(i % 8));
      chk("tc3", i, 32'(bus3.tc),
          32'((i % 8) == 7));
      chk("wrap3", i, 32'(bus3.wrap),
          32'(i == 8));
    end

    // long free run against a mod-16 model
    rst = 1'b0;
    step();
    chk("q_long_rst", 0, 32'(bus4.q), 32'd0);
    rst = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step();
      chk("q_long", i, 32'(bus4.q), 32'(i % 16));
      chk("tc_long", i, 32'(bus4.tc),
          32'((i % 16) == 15));
      chk("wrap_long", i, 32'(bus4.wrap),
          32'((i % 16) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
